// File: rtl/alu_issue_ctrl.sv
// Purpose: single-op issue/response controller between a requester and a multi-cycle ALU.
// Latency: ADD/MAX/RELU response two edges after accept (accept edge counted as the first); MUL/FMA add MUL_WAIT edges.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready; alu_ready=0 stalls EXEC. Option macro: ALU_ISSUE_STICKY_OVF_EN.

package warp_pkg;
  parameter int DATA_WIDTH = 32;

  // OP_ADD must stay at encoding 0: the ALU-side opcode resets to it.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_FMA  = 4'd3,
    OP_MAX  = 4'd4,
    OP_RELU = 4'd5
  } alu_opcode_e;
endpackage

module alu_issue_ctrl
  import warp_pkg::*;
#(
  parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = 4,
  parameter int MUL_WAIT   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  alu_opcode_e           req_opcode,
  input  logic [DATA_WIDTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0] req_op2,
  input  logic [DATA_WIDTH-1:0] req_op3,
  input  logic [TAG_WIDTH-1:0]  req_tag,

  output alu_opcode_e           alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [DATA_WIDTH-1:0] alu_operand3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  alu_ready,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic [TAG_WIDTH-1:0]  rsp_tag,

  input  logic                  clr_sticky,
  output logic                  sticky_ovf,
  output logic [CNT_WIDTH-1:0]  op_count
);

  // The wait counter is 4 bits wide, which bounds MUL_WAIT to 0..15.
  localparam logic [3:0] MUL_WAIT_C = 4'(MUL_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Everything the ALU needs for one op, captured on accept.
  typedef struct packed {
    alu_opcode_e           opcode;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] op3;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  // Response payload, frozen from capture until the handshake.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  state_e     state;
  req_t       req_q;
  rsp_t       rsp_q;
  logic       rsp_valid_q;
  logic [3:0] wait_cnt;
  logic       rsp_fire;
  logic       is_long_op;

  assign is_long_op = (req_opcode == OP_MUL) || (req_opcode == OP_FMA);
  assign rsp_fire   = rsp_valid_q && rsp_ready;

  // One op in flight: only the IDLE state can take a new request.
  assign req_ready = (state == S_IDLE);

  // ALU inputs come straight from the latched request so they cannot move during EXEC.
  assign alu_opcode   = req_q.opcode;
  assign alu_operand1 = req_q.op1;
  assign alu_operand2 = req_q.op2;
  assign alu_operand3 = req_q.op3;

  // rsp_valid is a flop, so it never has a combinational path from rsp_ready.
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_q.result;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_tag      = rsp_q.tag;

  // Issue FSM: accept in IDLE, wait out long ops and ALU stalls in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      wait_cnt    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q <= '{opcode: req_opcode,
                       op1:    req_op1,
                       op2:    req_op2,
                       op3:    req_op3,
                       tag:    req_tag};
            wait_cnt <= is_long_op ? MUL_WAIT_C : 4'd0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Extra multiply cycles are burned before alu_ready is even looked at.
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (alu_ready) begin
            rsp_q <= '{result:   alu_result,
                       overflow: alu_overflow,
                       tag:      req_q.tag};
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // Completed-op counter; free-running wrap is intentional.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      op_count <= op_count + 1'b1;
    end
  end

`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic sticky_q;

  // Sticky overflow: a delivered overflow beats a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (rsp_fire && rsp_q.overflow) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  // Feature compiled out: keep the port, ignore the clear.
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default warp_pkg::DATA_WIDTH, operand/result width.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, request/response tag width.
REQ-003 SHALL have parameter MUL_WAIT, default 1, extra EXEC cycles for OP_MUL/OP_FMA (0..15).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, completed-op counter width.
REQ-005 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req_valid in 1, req_ready out 1, req_opcode in warp_pkg::alu_opcode_e, req_op1/req_op2/req_op3 in DATA_WIDTH each, req_tag in TAG_WIDTH.
REQ-007 SHALL have ALU-side ports: alu_opcode out alu_opcode_e, alu_operand1/2/3 out DATA_WIDTH, alu_result in DATA_WIDTH, alu_overflow in 1, alu_ready in 1.
REQ-008 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_result out DATA_WIDTH, rsp_overflow out 1, rsp_tag out TAG_WIDTH.
REQ-009 SHALL have ports: clr_sticky in 1, sticky_ovf out 1, op_count out CNT_WIDTH.

Function
REQ-010 SHALL implement FSM IDLE, EXEC, RESP; reset state IDLE.
REQ-011 req_ready SHALL be 1 only in IDLE (combinational from state).
REQ-012 IDLE: req_valid=1 at clock edge -> latch opcode, op1..op3, tag into registers; go EXEC; load wait counter with MUL_WAIT for OP_MUL/OP_FMA, else 0.
REQ-013 alu_opcode/alu_operand1..3 SHALL be driven from the latched registers at all times (stable through EXEC); 0 / OP_ADD encoding value after reset.
REQ-014 EXEC: counter>0 -> decrement, stay; counter==0 and alu_ready=1 -> capture alu_result, alu_overflow, tag into response registers, go RESP; alu_ready=0 -> stay, no capture.
REQ-015 RESP: rsp_valid=1; rsp_result/rsp_overflow/rsp_tag stable until handshake; rsp_ready=1 -> IDLE; rsp_ready=0 -> hold.
REQ-016 Latency: ADD/MAX/RELU rsp_valid asserts 2 edges after accept edge; MUL/FMA 2+MUL_WAIT edges (alu_ready=1 throughout).
REQ-017 No new request accepted until the response handshake completes (one op in flight); back-to-back throughput = one op per 3+wait cycles minimum.
REQ-018 Unlisted opcodes SHALL be passed to the ALU unchanged; response is whatever ALU returns, no error flag.
REQ-019 op_count SHALL increment by 1 on each rsp_valid&&rsp_ready edge; wraps from all-ones to 0.
REQ-020 rsp_valid SHALL never depend combinationally on rsp_ready.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_tag=0, op_count=0, sticky_ovf=0, latched operands/opcode=0, wait counter=0.
REQ-022 Reset during EXEC or RESP SHALL discard the in-flight op; no response produced after release.
REQ-023 First request SHALL be accepted on the first edge after rst_n deasserts with req_valid=1.

Configuration
REQ-024 Macro ALU_ISSUE_STICKY_OVF_EN defined: sticky_ovf sets on any response handshake with rsp_overflow=1, clears on clr_sticky=1; same-edge set and clear -> set wins.
REQ-025 Macro undefined: sticky_ovf tied 0, clr_sticky ignored; all other behaviour identical; ports unchanged.

Verification
REQ-026 ADD op1=0x7FFFFFFF, op2=1, tag=3, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_result=0x80000000, rsp_overflow=1, rsp_tag=3, op_count=1.
REQ-027 MUL op1=6, op2=7, MUL_WAIT=1 -> rsp_valid 3 edges after accept, rsp_result=42, rsp_overflow=0; req_ready=0 until response taken.
REQ-028 FMA op1=2, op2=3, op3=4 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_result=10 stable, rsp_tag stable; handshake on cycle 6 -> IDLE, req_ready=1 next cycle.
REQ-029 alu_ready=0 for 4 cycles in EXEC -> no capture, alu_operand1..3 stable; alu_ready=1 -> RESP next edge.
REQ-030 rst_n pulsed low during RESP of RELU op1=0xFFFFFFFF -> rsp_valid=0 immediately, op_count=0, no response after release.
REQ-031 With ALU_ISSUE_STICKY_OVF_EN: overflowing ADD then clr_sticky=1 on the same edge as a second overflowing handshake -> sticky_ovf stays 1; later clr_sticky alone -> 0; without macro sticky_ovf always 0.
